rgb_hue_sequencer: RTL and testbench
====================================

Name: rgb_hue_sequencer

Overview:
- Controller that sequences the RGB PWM datapath around the hue wheel: red → yellow → green → cyan → blue → magenta → red.
- Generates three DUTY_W-bit duty values, advancing one ramp step every STEP_CYCLES clocks.
- Commits new duties only on a PWM frame boundary (frame_start), so the PWM channels never see a mid-period duty change.
- Sits between the top-level mode inputs and the per-colour PWM comparators that drive RGB_R/G/B.

Parameters:
- DUTY_W, 8, width of each duty value; MAX = 2^DUTY_W - 1.
- STEP_CYCLES, 46875, clocks per ramp step (12 MHz / 46875 = 256 steps/s, i.e. one sector per second at DUTY_W=8); legal range ≥ 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = sequencer active; 0 = dark, position cleared
- pause  in  1  1 = freeze hue position, keep outputs lit
- frame_start  in  1  one-cycle pulse from the PWM counter at the start of each PWM period
- duty_r  out  DUTY_W  committed red duty
- duty_g  out  DUTY_W  committed green duty
- duty_b  out  DUTY_W  committed blue duty
- duty_update  out  1  one-cycle pulse, high in the cycle the duties change register value (commit)
- wheel_wrap  out  1  one-cycle pulse when sector 5 rolls over to sector 0
- sector  out  3  current hue sector, 0..5

Behaviour:
- Clocking and reset: one clock domain; reset is asynchronous and active-low on rst_n.
- Reset values: state=OFF; sector=0; ramp=0; prescaler=0; duty_r/g/b=0; duty_update=0; wheel_wrap=0.
- Reset asserted mid-frame clears everything immediately. No commit happens until the first frame_start after release.
- FSM states: OFF, RUN, PAUSE.
  - Any state with enable=0 → OFF. This has top priority.
  - OFF with enable=1 → RUN, or → PAUSE if pause=1.
  - RUN with pause=1 → PAUSE.
  - PAUSE with pause=0 → RUN.
- In OFF: sector, ramp and prescaler are held at 0.
- Prescaler and step tick:
  - Counts only in RUN: 0..STEP_CYCLES-1, then wraps to 0.
  - tick is asserted in the cycle the count equals STEP_CYCLES-1.
  - In PAUSE the prescaler holds its value.
  - STEP_CYCLES=1 means tick every RUN cycle.
- Advance on tick:
  - If ramp < MAX: ramp += 1.
  - Else: ramp = 0 and sector = (sector==5) ? 0 : sector+1.
  - wheel_wrap is a registered pulse, high the cycle after the tick that takes sector from 5 to 0.
- Shadow duty (combinational from sector and ramp; up = ramp, dn = MAX - ramp):
  - sector 0: R=MAX, G=up, B=0
  - sector 1: R=dn, G=MAX, B=0
  - sector 2: R=0, G=MAX, B=up
  - sector 3: R=0, G=dn, B=MAX
  - sector 4: R=up, G=0, B=MAX
  - sector 5: R=MAX, G=0, B=dn
  - sector values 6/7 are unreachable; decode them as all 0.
- Commit on frame_start:
  - At the clock edge where frame_start=1, duty_* ← shadow; in OFF, duty_* ← 0.
  - duty_update=1 in the following cycle, for exactly one cycle. It pulses on every frame_start, including in OFF and PAUSE.
  - Latency from frame_start to a visible duty change is 1 clock.
- Simultaneous tick and frame_start: the commit uses pre-tick sector/ramp. The advanced value appears at the next frame_start.
- enable falling mid-frame: duties stay lit until the next frame_start, which then commits 0. There is no abrupt cut inside a PWM period.
- frame_start held high across several cycles: commits every cycle. This is legal but is not required usage.

Decomposition:
- Package rgb_pkg:
  - typedef enum hue_state_e {OFF, RUN, PAUSE}
  - typedef logic [2:0] sector_t
  - localparam NUM_SECTORS = 6
  - function hue_to_rgb(sector, ramp) returning the three shadow duties.
- One sub-module: step_prescaler (parameter STEP_CYCLES; inputs run/clear; output tick). The FSM, ramp/sector counters and commit registers stay in rgb_hue_sequencer.

Test Plan (DUTY_W=8, STEP_CYCLES=4, frame_start every 16 clocks unless stated):
- Reset with rst_n=0 for 3 clocks, enable=0, frame_starts running → all duties 0, sector 0, duty_update pulses 1 clock after each frame_start, wheel_wrap never asserted.
- enable=1, run 64 ticks (256 clocks) → at a subsequent frame_start the committed duties are R=255, G=64, B=0 (±1 step at the frame edge), sector=0.
- Run a full wheel of 6×256 ticks = 6144 clocks → exactly one wheel_wrap pulse; sector sequence is 0,1,2,3,4,5,0; at the sector 2→3 boundary the committed duties are R=0, G=255, B=255.
- pause=1 for 200 clocks mid-sector-1 → sector/ramp/duties unchanged across frame_starts; after pause=0, ramp resumes from the same prescaler count.
- Force tick and frame_start on the same edge (frame_start every 4 clocks aligned with tick) → committed duty equals the pre-tick shadow; the new value appears 4 clocks later.
- enable drops 5 clocks after a frame_start → duties hold until the next frame_start, then become 0; re-enable → first commit is R=255, G=0 or 1, B=0 (restart from red).
- Assert rst_n=0 asynchronously between clock edges mid-run → outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared types and the hue-wheel duty decode used by the RGB hue sequencer.
package rgb_pkg;

  typedef enum logic [1:0] {OFF, RUN, PAUSE} hue_state_e;
  typedef logic [2:0] sector_t;

  localparam int NUM_SECTORS = 6;
  localparam int HUE_W       = 16;

  typedef struct packed {
    logic [HUE_W-1:0] r;
    logic [HUE_W-1:0] g;
    logic [HUE_W-1:0] b;
  } rgb_duty_t;

  // Decoded at HUE_W bits; narrower callers zero-extend ramp/max and keep the low bits.
  function automatic rgb_duty_t hue_to_rgb(input sector_t          sector,
                                           input logic [HUE_W-1:0] ramp,
                                           input logic [HUE_W-1:0] max_duty);
    rgb_duty_t        duty;
    logic [HUE_W-1:0] dn;
    dn   = max_duty - ramp;
    duty = '0;
    case (sector)
      3'd0:    begin duty.r = max_duty; duty.g = ramp;     end
      3'd1:    begin duty.r = dn;       duty.g = max_duty; end
      3'd2:    begin duty.g = max_duty; duty.b = ramp;     end
      3'd3:    begin duty.g = dn;       duty.b = max_duty; end
      3'd4:    begin duty.r = ramp;     duty.b = max_duty; end
      3'd5:    begin duty.r = max_duty; duty.b = dn;       end
      default: duty = '0;
    endcase
    return duty;
  endfunction

endpackage

// File: rtl/rgb_hue_sequencer_prescaler.sv
// Step prescaler: free-running divider that emits one tick every STEP_CYCLES cycles of run.
import rgb_pkg::*;

module step_prescaler #(
  parameter int STEP_CYCLES = 46875
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign tick = run && (count == LAST);

  // Count is held (not cleared) while run is low so a pause resumes mid-step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rgb_hue_sequencer.sv
// Walks the RGB duties around the hue wheel and commits them to the PWM only on frame_start.
// DUTY_W must not exceed rgb_pkg::HUE_W.
import rgb_pkg::*;

module rgb_hue_sequencer #(
  parameter int DUTY_W      = 8,
  parameter int STEP_CYCLES = 46875
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              pause,
  input  logic              frame_start,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b,
  output logic              duty_update,
  output logic              wheel_wrap,
  output logic [2:0]        sector
);

  localparam logic [DUTY_W-1:0] MAX = '1;

  hue_state_e        state;
  hue_state_e        next_state;
  logic              run_step;
  logic              clear_pos;
  logic              tick;
  logic              at_wrap;
  logic [DUTY_W-1:0] ramp;
  rgb_duty_t         shadow;
  rgb_duty_t         shadow_unused;

  step_prescaler #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run_step),
    .clear(clear_pos),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= OFF;
    else        state <= next_state;
  end

  // enable low always wins and drops straight to OFF.
  always_comb begin
    next_state = state;
    run_step   = (state == RUN);
    clear_pos  = (state == OFF);
    if (!enable) begin
      next_state = OFF;
    end else begin
      case (state)
        OFF:     next_state = pause ? PAUSE : RUN;
        RUN:     if (pause)  next_state = PAUSE;
        PAUSE:   if (!pause) next_state = RUN;
        default: next_state = OFF;
      endcase
    end
  end

  assign at_wrap = (ramp == MAX) && (sector == sector_t'(NUM_SECTORS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sector     <= '0;
      ramp       <= '0;
      wheel_wrap <= 1'b0;
    end else begin
      wheel_wrap <= tick && at_wrap;
      if (clear_pos) begin
        sector <= '0;
        ramp   <= '0;
      end else if (tick) begin
        if (ramp == MAX) begin
          ramp   <= '0;
          sector <= at_wrap ? '0 : sector + 3'd1;
        end else begin
          ramp <= ramp + DUTY_W'(1);
        end
      end
    end
  end

  assign shadow        = hue_to_rgb(sector, HUE_W'(ramp), HUE_W'(MAX));
  assign shadow_unused = shadow;

  // Commit samples the pre-tick shadow, so a same-edge step shows up one frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_r      <= '0;
      duty_g      <= '0;
      duty_b      <= '0;
      duty_update <= 1'b0;
    end else begin
      duty_update <= frame_start;
      if (frame_start) begin
        if (state == OFF) begin
          duty_r <= '0;
          duty_g <= '0;
          duty_b <= '0;
        end else begin
          duty_r <= shadow.r[DUTY_W-1:0];
          duty_g <= shadow.g[DUTY_W-1:0];
          duty_b <= shadow.b[DUTY_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Scoreboard bench for rgb_hue_sequencer: a position-count model queues expected commits, a monitor pops them.
module tb_rgb_hue_sequencer;

  localparam int DUTY_W = 8;
  localparam int STEP   = 4;
  localparam int WHEEL  = 6 * 256 * STEP;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              pause = 1'b0;
  logic              frame_start = 1'b0;
  logic [DUTY_W-1:0] duty_r;
  logic [DUTY_W-1:0] duty_g;
  logic [DUTY_W-1:0] duty_b;
  logic              duty_update;
  logic              wheel_wrap;
  logic [2:0]        sector;

  typedef struct {
    int r;
    int g;
    int b;
  } rgb_t;

  typedef enum {M_OFF, M_RUN, M_PAUSE} m_state_e;

  int       n_cmp = 0;
  int       n_fail = 0;
  int       fcnt = 0;
  int       runcyc = 0;
  int       wrap_seen = 0;
  int       last_logged = 0;
  bit       log_en = 1'b0;
  bit       m_upd = 1'b0;
  bit       m_wrap = 1'b0;
  m_state_e m_state = M_OFF;
  rgb_t     m_duty = '{0, 0, 0};
  rgb_t     exp_q[$];
  int       seq[$];

  rgb_hue_sequencer #(
    .DUTY_W     (DUTY_W),
    .STEP_CYCLES(STEP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pause      (pause),
    .frame_start(frame_start),
    .duty_r     (duty_r),
    .duty_g     (duty_g),
    .duty_b     (duty_b),
    .duty_update(duty_update),
    .wheel_wrap (wheel_wrap),
    .sector     (sector)
  );

  always #5 clk = ~clk;

  // Piecewise-linear hue wheel over 1536 positions (6 sectors x 256 steps).
  function automatic rgb_t ref_rgb(int pos);
    rgb_t c;
    int   h;
    h = pos % 1536;
    if (h < 256 || h >= 1280) c.r = 255;
    else if (h < 512)         c.r = 511 - h;
    else if (h < 1024)        c.r = 0;
    else                      c.r = h - 1024;
    if (h < 256)              c.g = h;
    else if (h < 768)         c.g = 255;
    else if (h < 1024)        c.g = 1023 - h;
    else                      c.g = 0;
    if (h < 512)              c.b = 0;
    else if (h < 768)         c.b = h - 512;
    else if (h < 1280)        c.b = 255;
    else                      c.b = 1535 - h;
    return c;
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkRgb(string name, int r, int g, int b);
    checkOutput({name, "_r"}, int'(duty_r), r);
    checkOutput({name, "_g"}, int'(duty_g), g);
    checkOutput({name, "_b"}, int'(duty_b), b);
  endtask

  // Each iteration drives one clock; fcnt numbers the iterations so frame placement is exact.
  task automatic applyStimulus(int n, int period, int phase);
    for (int i = 0; i < n; i++) begin
      frame_start = ((fcnt % period) == phase);
      @(negedge clk);
      fcnt++;
    end
    frame_start = 1'b0;
  endtask

  // Reference model: hue position is just the number of RUN cycles since leaving OFF, divided by STEP.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = M_OFF;
      runcyc  = 0;
      m_duty  = '{0, 0, 0};
      m_upd   = 1'b0;
      m_wrap  = 1'b0;
      exp_q.delete();
    end else begin
      m_upd  = frame_start;
      m_wrap = 1'b0;
      if (frame_start) begin
        m_duty = (m_state == M_OFF) ? '{0, 0, 0} : ref_rgb(runcyc / STEP);
        exp_q.push_back(m_duty);
      end
      if (m_state == M_RUN) begin
        runcyc++;
        if (runcyc % WHEEL == 0) m_wrap = 1'b1;
      end else if (m_state == M_OFF) begin
        runcyc = 0;
      end
      if (!enable)                   m_state = M_OFF;
      else if (m_state == M_OFF)     m_state = pause ? M_PAUSE : M_RUN;
      else if (pause)                m_state = M_PAUSE;
      else                           m_state = M_RUN;
    end
  end

  // Monitor: pops one expected commit per duty_update and checks held values every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      rgb_t e;
      if (duty_update || m_upd) checkOutput("duty_update", int'(duty_update), int'(m_upd));
      if (duty_update) begin
        if (exp_q.size() == 0) begin
          checkOutput("commit_queue_depth", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          checkRgb("commit", e.r, e.g, e.b);
        end
      end
      checkRgb("hold", m_duty.r, m_duty.g, m_duty.b);
      checkOutput("sector", int'(sector), (runcyc / (STEP * 256)) % 6);
      if (wheel_wrap || m_wrap) checkOutput("wheel_wrap", int'(wheel_wrap), int'(m_wrap));
      if (wheel_wrap) wrap_seen++;
      if (log_en && int'(sector) != last_logged) begin
        seq.push_back(int'(sector));
        last_logged = int'(sector);
      end
    end
  end

  initial begin
    int exp_seq[7];
    exp_seq = '{0, 1, 2, 3, 4, 5, 0};

    // Reset held, then released with the sequencer disabled: frames commit zeros.
    applyStimulus(3, 16, 1);
    rst_n = 1'b1;
    applyStimulus(48, 16, 1);
    checkRgb("off_duty", 0, 0, 0);
    checkOutput("off_sector", int'(sector), 0);
    checkOutput("off_wraps", wrap_seen, 0);

    // Enable: frame at iteration 257 commits the shadow after 64 ticks.
    fcnt   = 0;
    enable = 1'b1;
    applyStimulus(258, 16, 1);
    checkOutput("ramp64_update", int'(duty_update), 1);
    checkRgb("ramp64", 255, 64, 0);
    checkOutput("ramp64_sector", int'(sector), 0);

    // Full wheel; iteration 3073 commits the first sector-3 position.
    log_en      = 1'b1;
    last_logged = 0;
    seq.push_back(0);
    applyStimulus(2816, 16, 1);
    checkRgb("sector3_edge", 0, 255, 255);
    checkOutput("sector3_sector", int'(sector), 3);
    applyStimulus(3326, 16, 1);
    log_en = 1'b0;
    checkOutput("wheel_wraps", wrap_seen, 1);
    checkOutput("seq_len", seq.size(), 7);
    for (int i = 0; i < 7 && i < seq.size(); i++) checkOutput($sformatf("seq_%0d", i), seq[i], exp_seq[i]);

    // Pause mid-sector-1 with the prescaler at count 2.
    applyStimulus(1166, 16, 1);
    pause = 1'b1;
    applyStimulus(200, 16, 1);
    checkRgb("paused", 156, 255, 0);
    checkOutput("paused_sector", int'(sector), 1);
    pause = 1'b0;
    applyStimulus(12, 16, 1);
    checkRgb("resumed", 153, 255, 0);

    // Frames every 4 clocks, landing on the tick edge.
    applyStimulus(3, 4, 0);
    checkRgb("tick_frame_pre", 153, 255, 0);
    applyStimulus(4, 4, 0);
    checkRgb("tick_frame_post", 152, 255, 0);

    // enable drops 5 clocks after a frame: hold until next frame, then dark.
    applyStimulus(9, 16, 1);
    applyStimulus(5, 16, 1);
    enable = 1'b0;
    applyStimulus(10, 16, 1);
    checkRgb("disable_hold", 149, 255, 0);
    applyStimulus(1, 16, 1);
    checkRgb("disable_dark", 0, 0, 0);
    checkOutput("disable_sector", int'(sector), 0);
    applyStimulus(12, 16, 1);
    enable = 1'b1;
    applyStimulus(4, 16, 1);
    checkRgb("reenable", 255, 0, 0);
    applyStimulus(20, 16, 1);
    checkRgb("pre_reset", 255, 4, 0);

    // Asynchronous reset in the middle of the low clock phase.
    #2 rst_n = 1'b0;
    #1;
    checkRgb("async_reset", 0, 0, 0);
    checkOutput("async_reset_sector", int'(sector), 0);
    checkOutput("async_reset_update", int'(duty_update), 0);
    applyStimulus(2, 16, 1);
    rst_n = 1'b1;
    applyStimulus(40, 16, 1);

    #1;
    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("total_wraps", wrap_seen, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
